// File: rtl/barcode_pkg.sv
// ----------------------------------------------------------------------------
// barcode_pkg
// Types and default constants for the bar-width measurement path.
//   bar_token_t   : one measured run (level, width in cycles, scan-closing flag)
//   meter_state_t : measurement FSM states
//   *_DEF         : default parameter values for bar_width_meter / token_fifo
// ----------------------------------------------------------------------------
package barcode_pkg;

   localparam int CNT_W_DEF      = 16;
   localparam int DEBOUNCE_DEF   = 4;
   localparam int TIMEOUT_DEF    = 50000;
   localparam int FIFO_DEPTH_DEF = 4;

   typedef struct packed {
      logic                 level;
      logic [CNT_W_DEF-1:0] width;
      logic                 last;
   } bar_token_t;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } meter_state_t;

endpackage

// File: rtl/token_fifo.sv
// ----------------------------------------------------------------------------
// token_fifo
// Synchronous show-ahead FIFO of packed tokens. DEPTH must be a power of two
// and at least 2.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data; accepted when not full, or when full and a
//                pop happens in the same cycle
//   full       : no free entry (before this cycle's pop)
//   pop        : remove the head entry (ignored when empty)
//   pop_data   : head entry, forced to zero while empty
//   empty      : no entries
// ----------------------------------------------------------------------------
module token_fifo
   import barcode_pkg::*;
#(
   parameter int  DEPTH = FIFO_DEPTH_DEF,
   parameter type T     = bar_token_t
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     push_data,
   output logic full,
   input  logic pop,
   output T     pop_data,
   output logic empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T            mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A slot freed by a same-cycle pop may be refilled immediately.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; the read port is masked while empty instead.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   always_comb begin
      pop_data = '0;
      if (!empty) pop_data = mem[rd_ptr[AW-1:0]];
   end

endmodule

// File: rtl/bar_width_meter.sv
// ----------------------------------------------------------------------------
// bar_width_meter
// Debounces the synchronized scanner level, measures the length of every bar
// (1) and space (0) in clock cycles, closes a scan after a long quiet space,
// and queues (level, width, last) tokens for the decoder.
//   clk, reset : clock, synchronous active-high reset
//   synced     : synchronized sensor level (1 = dark bar, 0 = light space)
//   enable     : measurement enable; low aborts any run in progress
//   tok_valid  : FIFO head valid
//   tok_ready  : consumer accepts head
//   tok_level  : level of the measured run
//   tok_width  : run length in cycles
//   tok_last   : token closes a scan (timeout)
//   overflow   : sticky, a token was dropped because the FIFO was full
//   busy       : measurement FSM is in MEASURE
//
// Handshake: a token transfers on every rising clk edge where tok_valid and
// tok_ready are both high. tok_valid never depends on tok_ready, and once
// tok_valid is high the tok_* fields stay stable until the transfer happens.
// ----------------------------------------------------------------------------
module bar_width_meter
   import barcode_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DEBOUNCE   = DEBOUNCE_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             synced,
   input  logic             enable,
   output logic             tok_valid,
   input  logic             tok_ready,
   output logic             tok_level,
   output logic [CNT_W-1:0] tok_width,
   output logic             tok_last,
   output logic             overflow,
   output logic             busy
);

   localparam int               DEB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TO_WIDTH = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef struct packed {
      logic             level;
      logic [CNT_W-1:0] width;
      logic             last;
   } tok_t;

   logic             lvl;
   logic [DEB_W-1:0] deb_cnt;
   meter_state_t     state;
   meter_state_t     state_next;
   logic [CNT_W-1:0] run_cnt;
   logic             run_level;
   logic             level_change;
   logic             timeout_hit;
   logic             push;
   tok_t             push_tok;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   tok_t             head;

   // ---------------- debounce ----------------
   // lvl only follows synced after DEBOUNCE consecutive differing samples, so
   // rising and falling edges are delayed by the same amount and measured
   // widths equal the raw pulse widths.
   always_ff @(posedge clk) begin
      if (reset) begin
         lvl     <= 1'b0;
         deb_cnt <= '0;
      end else if (synced != lvl) begin
         if (deb_cnt == DEB_LAST) begin
            lvl     <= synced;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end else begin
         deb_cnt <= '0;
      end
   end

   // ---------------- measurement FSM ----------------
   // run_level remembers which level run_cnt is counting, so a level change
   // is seen as lvl != run_level.
   assign level_change = (lvl != run_level);
   // A space that has just reached TIMEOUT cycles ends the scan.
   assign timeout_hit  = !level_change && !run_level && (run_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable && lvl) state_next = MEASURE;
         MEASURE: if (!enable || timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == MEASURE);
      push     = 1'b0;
      push_tok = '0;
      if (state == MEASURE && enable) begin
         if (level_change) begin
            push           = 1'b1;
            push_tok.level = run_level;
            push_tok.width = run_cnt;
         end else if (timeout_hit) begin
            push           = 1'b1;
            push_tok.level = 1'b0;
            push_tok.width = TO_WIDTH;
            push_tok.last  = 1'b1;
         end
      end
   end

   // Run-length counter: restarts at 1 on the first cycle of each run and
   // saturates rather than wrapping on very long bars.
   always_ff @(posedge clk) begin
      if (reset) begin
         run_cnt   <= '0;
         run_level <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable && lvl) begin
                  run_cnt   <= CNT_ONE;
                  run_level <= 1'b1;
               end else begin
                  run_cnt <= '0;
               end
            end
            MEASURE: begin
               if (!enable || timeout_hit) begin
                  run_cnt <= '0;
               end else if (level_change) begin
                  run_cnt   <= CNT_ONE;
                  run_level <= lvl;
               end else if (run_cnt != '1) begin
                  run_cnt <= run_cnt + 1'b1;
               end
            end
            default: run_cnt <= '0;
         endcase
      end
   end

   // ---------------- token buffer ----------------
   assign tok_valid = !fifo_empty;
   assign pop       = tok_valid && tok_ready;

   token_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (tok_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_tok),
      .full      (fifo_full),
      .pop       (pop),
      .pop_data  (head),
      .empty     (fifo_empty)
   );

   assign tok_level = head.level;
   assign tok_width = head.width;
   assign tok_last  = head.last;

   // A push is lost only when the FIFO is full and nothing leaves this cycle.
   always_ff @(posedge clk) begin
      if (reset)                          overflow <= 1'b0;
      else if (push && fifo_full && !pop) overflow <= 1'b1;
   end

endmodule

// File: tb/tb_bar_width_meter.sv
// ----------------------------------------------------------------------------
// tb_bar_width_meter
// Bench for bar_width_meter (CNT_W=16, DEBOUNCE=4, TIMEOUT=100, FIFO_DEPTH=4).
// A reference model computes the expected token queue from the sensor rules;
// a compare process checks the outputs against it every cycle, and directed
// scenarios pin the model with hand-computed tokens.
// ----------------------------------------------------------------------------
module tb_bar_width_meter;

   localparam int CNT_W      = 16;
   localparam int DEBOUNCE   = 4;
   localparam int TIMEOUT    = 100;
   localparam int FIFO_DEPTH = 4;
   localparam int TOK_W      = CNT_W + 2;
   localparam int MAX_W      = (1 << CNT_W) - 1;

   // ---------------- clock / reset / DUT ----------------
   logic             clk = 1'b0;
   logic             reset;
   logic             synced;
   logic             enable;
   logic             tok_ready;
   logic             tok_valid;
   logic             tok_level;
   logic [CNT_W-1:0] tok_width;
   logic             tok_last;
   logic             overflow;
   logic             busy;

   always #5 clk = ~clk;

   bar_width_meter #(
      .CNT_W      (CNT_W),
      .DEBOUNCE   (DEBOUNCE),
      .TIMEOUT    (TIMEOUT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .synced    (synced),
      .enable    (enable),
      .tok_valid (tok_valid),
      .tok_ready (tok_ready),
      .tok_level (tok_level),
      .tok_width (tok_width),
      .tok_last  (tok_last),
      .overflow  (overflow),
      .busy      (busy)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // exp_q is the expected FIFO content (head first).
   logic [TOK_W-1:0] exp_q [$];
   logic             hist  [$];   // most recent synced samples, newest last
   logic             m_lvl;
   bit               m_active;
   logic             m_run_lvl;
   int               m_start;
   bit               m_ovf;

   always @(posedge clk) begin : model
      bit               do_pop;
      bit               have_push;
      bit               flip;
      int               w;
      logic [TOK_W-1:0] ptok;
      if (reset) begin
         exp_q.delete();
         hist.delete();
         m_lvl     = 1'b0;
         m_active  = 1'b0;
         m_run_lvl = 1'b0;
         m_ovf     = 1'b0;
      end else begin
         do_pop    = (exp_q.size() > 0) && tok_ready;
         have_push = 1'b0;
         ptok      = '0;
         // Runs are measured on the filtered level as it stood before this edge.
         if (!enable) begin
            m_active = 1'b0;
         end else if (!m_active) begin
            if (m_lvl) begin
               m_active  = 1'b1;
               m_run_lvl = 1'b1;
               m_start   = cyc;
            end
         end else if (m_lvl != m_run_lvl) begin
            w = cyc - m_start;
            if (w > MAX_W) w = MAX_W;
            have_push = 1'b1;
            ptok      = {m_run_lvl, CNT_W'(w), 1'b0};
            m_run_lvl = m_lvl;
            m_start   = cyc;
         end else if (!m_run_lvl && (cyc - m_start == TIMEOUT - 1)) begin
            have_push = 1'b1;
            ptok      = {1'b0, CNT_W'(TIMEOUT), 1'b1};
            m_active  = 1'b0;
         end
         if (do_pop) void'(exp_q.pop_front());
         if (have_push) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(ptok);
            else                           m_ovf = 1'b1;
         end
         // Filter: adopt the new level once the last DEBOUNCE samples all differ.
         hist.push_back(synced);
         if (hist.size() > DEBOUNCE) void'(hist.pop_front());
         flip = (hist.size() == DEBOUNCE);
         foreach (hist[k]) if (hist[k] == m_lvl) flip = 1'b0;
         if (flip) m_lvl = ~m_lvl;
      end
      cyc++;
   end

   // ---------------- compare / capture (negedge) ----------------
   logic [TOK_W-1:0] got_q [$];
   bit               quiet    = 1'b0;
   bit               lat_arm  = 1'b0;
   bit               lat_seen = 1'b0;
   int               lat_start;
   int               lat_cyc  = -1;

   always @(negedge clk) begin : compare
      logic [TOK_W-1:0] head;
      head = (exp_q.size() > 0) ? exp_q[0] : '0;
      chk("tok_valid", 32'(tok_valid), 32'(exp_q.size() > 0));
      chk("tok_level", 32'(tok_level), 32'(head[TOK_W-1]));
      chk("tok_width", 32'(tok_width), 32'(head[TOK_W-2:1]));
      chk("tok_last",  32'(tok_last),  32'(head[0]));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("busy",      32'(busy),      32'(m_active));
      if (quiet) begin
         chk("quiet_valid",    32'(tok_valid), 32'(0));
         chk("quiet_busy",     32'(busy),      32'(0));
         chk("quiet_overflow", 32'(overflow),  32'(0));
      end
      if (lat_arm && !lat_seen && tok_valid) begin
         lat_seen = 1'b1;
         lat_cyc  = cyc;
      end
      if (tok_valid && tok_ready && !reset)
         got_q.push_back({tok_level, tok_width, tok_last});
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic run(input logic s, input int n);
      synced = s;
      repeat (n) tick();
   endtask

   task automatic chk_tok(input string name, input int idx, input logic lv, input int w, input logic ls);
      logic [TOK_W-1:0] act;
      act = (got_q.size() > idx) ? got_q[idx] : '1;
      chk(name, 32'(act), 32'({lv, CNT_W'(w), ls}));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      int left;
      int en_off;
      reset     = 1'b1;
      synced    = 1'b0;
      enable    = 1'b1;
      tok_ready = 1'b1;

      // Reset held with the sensor toggling: everything stays quiet.
      quiet = 1'b1;
      for (int i = 0; i < 3; i++) begin
         synced = ~synced;
         tick();
      end
      reset = 1'b0;
      run(1'b0, 3);
      quiet = 1'b0;
      chk("rst_valid", 32'(tok_valid), 32'(0));
      chk("rst_overflow", 32'(overflow), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));

      // Basic scan with a consumer that is always ready.
      got_q.delete();
      run(1'b1, 10);
      lat_start = cyc;
      lat_arm   = 1'b1;
      run(1'b0, 20);
      run(1'b1, 5);
      run(1'b0, 130);
      lat_arm = 1'b0;
      chk("scan_count", 32'(got_q.size()), 32'(4));
      chk_tok("scan_tok0", 0, 1'b1, 10,  1'b0);
      chk_tok("scan_tok1", 1, 1'b0, 20,  1'b0);
      chk_tok("scan_tok2", 2, 1'b1, 5,   1'b0);
      chk_tok("scan_tok3", 3, 1'b0, 100, 1'b1);
      chk("scan_latency", 32'(lat_cyc - lat_start), 32'(DEBOUNCE + 1));
      chk("scan_busy_end", 32'(busy), 32'(0));

      // A short pulse vanishes; a short space inside a bar is absorbed.
      quiet = 1'b1;
      run(1'b1, 3);
      run(1'b0, 10);
      quiet = 1'b0;
      got_q.delete();
      run(1'b1, 10);
      run(1'b0, 2);
      run(1'b1, 10);
      run(1'b0, 130);
      chk_tok("glitch_tok0", 0, 1'b1, 22, 1'b0);
      chk_tok("glitch_tok1", 1, 1'b0, 100, 1'b1);

      // Stalled consumer: first four tokens kept, the rest dropped.
      tok_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run(1'b1, 6);
         run(1'b0, 6);
      end
      run(1'b1, 6);
      run(1'b0, 120);
      chk("ovf_set", 32'(overflow), 32'(1));
      chk("ovf_valid", 32'(tok_valid), 32'(1));
      got_q.delete();
      tok_ready = 1'b1;
      run(1'b0, 10);
      chk("ovf_drain_count", 32'(got_q.size()), 32'(4));
      chk_tok("ovf_tok0", 0, 1'b1, 6, 1'b0);
      chk_tok("ovf_tok1", 1, 1'b0, 6, 1'b0);
      chk_tok("ovf_tok2", 2, 1'b1, 6, 1'b0);
      chk_tok("ovf_tok3", 3, 1'b0, 6, 1'b0);
      chk("ovf_sticky", 32'(overflow), 32'(1));

      // Enable dropped mid-bar: the aborted run produces nothing.
      got_q.delete();
      run(1'b1, 7);
      enable = 1'b0;
      run(1'b1, 5);
      run(1'b0, 20);
      enable = 1'b1;
      run(1'b0, 10);
      run(1'b1, 8);
      run(1'b0, 130);
      chk("en_count", 32'(got_q.size()), 32'(2));
      chk_tok("en_tok0", 0, 1'b1, 8, 1'b0);
      chk_tok("en_tok1", 1, 1'b0, 100, 1'b1);

      // Full FIFO cleared by a one-cycle reset.
      tok_ready = 1'b0;
      run(1'b1, 6);
      run(1'b0, 6);
      run(1'b1, 6);
      run(1'b0, 6);
      run(1'b1, 8);
      chk("full_valid", 32'(tok_valid), 32'(1));
      chk("full_busy", 32'(busy), 32'(1));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_valid", 32'(tok_valid), 32'(0));
      chk("rst2_overflow", 32'(overflow), 32'(0));
      chk("rst2_busy", 32'(busy), 32'(0));
      run(1'b0, 10);

      // Randomized runs, consumer stalls, enable drops and rare resets.
      tok_ready = 1'b1;
      left   = 0;
      en_off = 0;
      for (int i = 0; i < 3000; i++) begin
         if (left == 0) begin
            synced = ~synced;
            left   = ($urandom_range(0, 15) == 0) ? $urandom_range(90, 130) : $urandom_range(1, 12);
         end
         left--;
         tok_ready = ($urandom_range(0, 3) != 0);
         if (en_off == 0 && $urandom_range(0, 299) == 0) en_off = $urandom_range(1, 30);
         enable = (en_off == 0);
         if (en_off > 0) en_off--;
         reset = ($urandom_range(0, 799) == 0);
         tick();
      end
      reset     = 1'b0;
      enable    = 1'b1;
      tok_ready = 1'b1;
      run(1'b0, 150);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
